// File: rtl/branch_resolver_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the RV32 branch-resolution stage.
//   branch_funct3_t  : encodings of the conditional-branch funct3 field
//   PC_STEP_DEFAULT  : sequential PC increment (one 32-bit instruction)
//   is_legal_branch  : 1 when funct3 names a defined conditional branch
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_funct3_t;

  localparam int PC_STEP_DEFAULT = 4;

  // 010 and 011 are the only undefined encodings in the branch opcode space.
  function automatic logic is_legal_branch(input logic [2:0] funct3);
    return (funct3[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// ---------------------------------------------------------------------------
// branch_resolver_if
// Request/result bus of the branch resolver.
//   master : upstream issue + fetch/PC-select consumer side (drives requests,
//            out_ready and flush)
//   slave  : the resolver itself
// Request : in_valid/in_ready handshake, in_funct3, in_a, in_b, in_pc, in_imm
// Result  : out_valid/out_ready handshake, out_taken, out_target,
//           out_next_pc, out_illegal, out_misaligned
// Control : flush (synchronous kill of the held result)
// ---------------------------------------------------------------------------
interface branch_resolver_if #(
  parameter int N = 32
);
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_funct3;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_pc;
  logic [N-1:0] in_imm;
  logic         out_valid;
  logic         out_ready;
  logic         out_taken;
  logic [N-1:0] out_target;
  logic [N-1:0] out_next_pc;
  logic         out_illegal;
  logic         out_misaligned;

  modport master (
    output flush, in_valid, in_funct3, in_a, in_b, in_pc, in_imm, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_next_pc,
           out_illegal, out_misaligned
  );

  modport slave (
    input  flush, in_valid, in_funct3, in_a, in_b, in_pc, in_imm, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_next_pc,
           out_illegal, out_misaligned
  );
endinterface

// File: rtl/branch_resolver_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch-condition evaluator.
//   funct3  : branch type
//   a, b    : rs1 / rs2 operands (N bits)
//   taken   : branch condition holds (always 0 for undefined funct3)
//   illegal : funct3 is not a defined conditional branch
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         taken,
  output logic         illegal
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    taken = 1'b0;
    case (branch_funct3_t'(funct3))
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt;
      BGE:     taken = !lt;
      BLTU:    taken = ltu;
      BGEU:    taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  assign illegal = !is_legal_branch(funct3);

endmodule

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
// Resolves one RV32 conditional branch per handshake and holds the result in a
// single-entry output register with backpressure and flush.
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   bus (slave)    : request/result bus, see branch_resolver_if
//   stat_resolved  : (BRANCH_RESOLVER_STATS_EN only) saturating count of
//                    drained results
//   stat_taken     : (BRANCH_RESOLVER_STATS_EN only) saturating count of
//                    drained taken results
// Optional feature macro: BRANCH_RESOLVER_STATS_EN
// ---------------------------------------------------------------------------
module branch_resolver
  import branch_pkg::*;
#(
  parameter int N       = 32,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  branch_resolver_if.slave bus
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_taken
`endif
);

  logic         cond_taken;
  logic         cond_illegal;
  logic [N-1:0] target_next;
  logic [N-1:0] seq_pc_next;
  logic [N-1:0] next_pc_next;
  logic         misaligned_next;
  logic         accept;
  logic         drain;

  logic         out_valid_reg;
  logic         out_taken_reg;
  logic         out_illegal_reg;
  logic         out_misaligned_reg;
  logic [N-1:0] out_target_reg;
  logic [N-1:0] out_next_pc_reg;

  branch_cond_eval #(.N(N)) u_cond (
    .funct3  (bus.in_funct3),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  // All adds are N-bit and wrap.
  assign target_next     = bus.in_pc + bus.in_imm;
  assign seq_pc_next     = bus.in_pc + N'(PC_STEP);
  assign next_pc_next    = cond_taken ? target_next : seq_pc_next;
  // Only a taken branch can fault on alignment; illegal encodings never take.
  assign misaligned_next = cond_taken && (target_next[1:0] != 2'b00);

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign drain        = out_valid_reg && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg      <= 1'b0;
      out_taken_reg      <= 1'b0;
      out_illegal_reg    <= 1'b0;
      out_misaligned_reg <= 1'b0;
      out_target_reg     <= '0;
      out_next_pc_reg    <= '0;
    end else begin
      // Flush wins over everything; data fields are left stale on purpose.
      if (bus.flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg      <= 1'b1;
        out_taken_reg      <= cond_taken;
        out_illegal_reg    <= cond_illegal;
        out_misaligned_reg <= misaligned_next;
        out_target_reg     <= target_next;
        out_next_pc_reg    <= next_pc_next;
      end else if (drain) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_reg;
  assign bus.out_taken      = out_taken_reg;
  assign bus.out_illegal    = out_illegal_reg;
  assign bus.out_misaligned = out_misaligned_reg;
  assign bus.out_target     = out_target_reg;
  assign bus.out_next_pc    = out_next_pc_reg;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_resolved_reg;
  logic [31:0] stat_taken_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved_reg <= '0;
      stat_taken_reg    <= '0;
    end else if (drain) begin
      if (stat_resolved_reg != 32'hFFFF_FFFF) begin
        stat_resolved_reg <= stat_resolved_reg + 32'd1;
      end
      if (out_taken_reg && (stat_taken_reg != 32'hFFFF_FFFF)) begin
        stat_taken_reg <= stat_taken_reg + 32'd1;
      end
    end
  end

  assign stat_resolved = stat_resolved_reg;
  assign stat_taken    = stat_taken_reg;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
// Directed bench for branch_resolver: a per-cycle comparison against a
// behavioural model plus hand-computed literal expectations.
// Honours BRANCH_RESOLVER_STATS_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_resolver;
  import branch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if #(.N(32)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_taken;
`endif

  branch_resolver #(.N(32), .PC_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_taken    (stat_taken)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic spec_taken(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  logic        m_valid;
  logic        m_taken, m_ill, m_mis;
  logic [31:0] m_target, m_next;
  int unsigned m_res, m_tak;

  logic        i_taken;
  logic [31:0] i_target;
  logic        m_accept;
  assign i_taken  = spec_taken(bus.in_funct3, bus.in_a, bus.in_b);
  assign i_target = bus.in_pc + bus.in_imm;
  assign m_accept = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0; m_taken <= 1'b0; m_ill <= 1'b0; m_mis <= 1'b0;
      m_target <= '0; m_next <= '0; m_res <= 0; m_tak <= 0;
    end else begin
      if (m_valid && bus.out_ready && !bus.flush) begin
        m_res <= m_res + 1;
        if (m_taken) m_tak <= m_tak + 1;
      end
      if (bus.flush) m_valid <= 1'b0;
      else if (m_accept) begin
        m_valid  <= 1'b1;
        m_taken  <= i_taken;
        m_ill    <= (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b011);
        m_target <= i_target;
        m_next   <= i_taken ? i_target : bus.in_pc + 32'd4;
        m_mis    <= i_taken && (i_target % 4 != 0);
      end else if (bus.out_ready) m_valid <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready", bus.in_ready, !m_valid || bus.out_ready);
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("out_taken", bus.out_taken, m_taken);
        chk("out_illegal", bus.out_illegal, m_ill);
        chk("out_misaligned", bus.out_misaligned, m_mis);
        chk("out_target", bus.out_target, m_target);
        chk("out_next_pc", bus.out_next_pc, m_next);
      end
`ifdef BRANCH_RESOLVER_STATS_EN
      chk("stat_resolved", stat_resolved, m_res);
      chk("stat_taken", stat_taken, m_tak);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.in_funct3 = f; bus.in_a = a; bus.in_b = b; bus.in_pc = pc; bus.in_imm = imm;
  endtask

  // One request through an idle stage with out_ready=1, literal checks on the result.
  task automatic xfer(input string name, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                      input logic e_taken, input logic [31:0] e_target,
                      input logic [31:0] e_next, input logic e_ill, input logic e_mis);
    drive(f, a, b, pc, imm);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1'b1);
    chk({name, "_taken"}, bus.out_taken, e_taken);
    chk({name, "_target"}, bus.out_target, e_target);
    chk({name, "_next_pc"}, bus.out_next_pc, e_next);
    chk({name, "_illegal"}, bus.out_illegal, e_ill);
    chk({name, "_misaligned"}, bus.out_misaligned, e_mis);
    $display("txn %s: taken=%0d target=%h next_pc=%h illegal=%0d misaligned=%0d",
             name, bus.out_taken, bus.out_target, bus.out_next_pc,
             bus.out_illegal, bus.out_misaligned);
    step();
  endtask

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] saved_res;
`endif

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    drive(3'b000, '0, '0, '0, '0);

    // Reset state
    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_taken", bus.out_taken, 1'b0);
    chk("rst_out_illegal", bus.out_illegal, 1'b0);
    chk("rst_out_misaligned", bus.out_misaligned, 1'b0);
    chk("rst_out_target", bus.out_target, 32'd0);
    chk("rst_out_next_pc", bus.out_next_pc, 32'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("rst_stat_resolved", stat_resolved, 32'd0);
    chk("rst_stat_taken", stat_taken, 32'd0);
`endif
    step();
    rst = 1'b1;
    step();

    // Condition and arithmetic cases
    xfer("beq",       3'b000, 32'd5, 32'd5, 32'd100, 32'd20, 1'b1, 32'd120, 32'd120, 1'b0, 1'b0);
    xfer("blt",       3'b100, 32'hFFFF_FFFF, 32'd1, 32'd200, 32'd16, 1'b1, 32'd216, 32'd216, 1'b0, 1'b0);
    xfer("bltu",      3'b110, 32'hFFFF_FFFF, 32'd1, 32'd200, 32'd16, 1'b0, 32'd216, 32'd204, 1'b0, 1'b0);
    xfer("bgeu",      3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd8, 1'b0, 32'd8, 32'd4, 1'b0, 1'b0);
    xfer("bge_nt",    3'b101, 32'hFFFF_FFFE, 32'd1, 32'd40, 32'hFFFF_FFFC, 1'b0, 32'd36, 32'd44, 1'b0, 1'b0);
    xfer("ill010",    3'b010, 32'd0, 32'd0, 32'd500, 32'd100, 1'b0, 32'd600, 32'd504, 1'b1, 1'b0);
    xfer("ill011",    3'b011, 32'd3, 32'd3, 32'd500, 32'd100, 1'b0, 32'd600, 32'd504, 1'b1, 1'b0);
    xfer("beq_mis",   3'b000, 32'd7, 32'd7, 32'd0, 32'd6, 1'b1, 32'd6, 32'd6, 1'b0, 1'b1);
    xfer("bne_nt_mis",3'b001, 32'd7, 32'd7, 32'd0, 32'd6, 1'b0, 32'd6, 32'd4, 1'b0, 1'b0);
    xfer("wrap",      3'b000, 32'd1, 32'd1, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'd4, 32'd4, 1'b0, 1'b0);

    // Backpressure: hold BNE while a BGE waits upstream
    drive(3'b001, 32'd1, 32'd2, 32'd300, 32'hFFFF_FFF8);
    bus.in_valid = 1'b1;
    step();
    bus.out_ready = 1'b0;
    drive(3'b101, 32'd3, 32'd2, 32'd400, 32'd12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 1'b0);
      chk("bp_valid", bus.out_valid, 1'b1);
      chk("bp_target", bus.out_target, 32'd292);
      chk("bp_next_pc", bus.out_next_pc, 32'd292);
      step();
    end
    $display("txn bp_hold: target=%h held for 3 cycles", bus.out_target);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_replace_valid", bus.out_valid, 1'b1);
    chk("bp_replace_target", bus.out_target, 32'd412);
    chk("bp_replace_taken", bus.out_taken, 1'b1);
    $display("txn bp_replace: target=%h taken=%0d", bus.out_target, bus.out_taken);
    step();

    // Flush of a stalled entry, with a concurrent request
    drive(3'b000, 32'd9, 32'd9, 32'd600, 32'd4);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
`ifdef BRANCH_RESOLVER_STATS_EN
    saved_res = stat_resolved;
`endif
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    drive(3'b000, 32'd1, 32'd1, 32'd700, 32'd8);
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", bus.out_valid, 1'b0);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("flush_stat_resolved", stat_resolved, saved_res);
`endif
    $display("txn flush_stalled: out_valid=%0d", bus.out_valid);
    step();
    // Flush on an empty stage with out_ready=1 must still block acceptance
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", bus.out_valid, 1'b0);
    $display("txn flush_empty: out_valid=%0d", bus.out_valid);
    step();

    // Asynchronous reset in the middle of a stall
    drive(3'b000, 32'd2, 32'd2, 32'd800, 32'd16);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", bus.out_valid, 1'b0);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("rst_mid_stat_resolved", stat_resolved, 32'd0);
`endif
    $display("txn rst_mid_stall: out_valid=%0d", bus.out_valid);
    step();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_no_replay", bus.out_valid, 1'b0);
    step();

    // Ten back-to-back taken branches
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(3'b000, i, i, i * 16, 32'd32);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("b2b_drained", bus.out_valid, 1'b0);
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("b2b_stat_resolved", stat_resolved, 32'd10);
    chk("b2b_stat_taken", stat_taken, 32'd10);
`endif
    $display("txn back_to_back: 10 taken branches issued");
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
